// File: rtl/riscv_pkg.sv
// Shared types and widths for the writeback stage.
// Holds the writeback FSM states, the load size encoding and the default register widths.
package riscv_pkg;

   localparam int REGISTER_WIDTH   = 64;
   localparam int REGISTERNO_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOAD = 2'd1,
      SYSCALL   = 2'd2
   } wb_state_t;

   typedef enum logic [1:0] {
      LS_B = 2'd0,
      LS_H = 2'd1,
      LS_W = 2'd2,
      LS_D = 2'd3
   } load_size_t;

   // Number of meaningful bits in a loaded field of the given size.
   function automatic int unsigned load_size_bits(input load_size_t size);
      case (size)
         LS_B:    load_size_bits = 32'd8;
         LS_H:    load_size_bits = 32'd16;
         LS_W:    load_size_bits = 32'd32;
         LS_D:    load_size_bits = 32'd64;
         default: load_size_bits = 32'd64;
      endcase
   endfunction

endpackage

// File: rtl/writeback_unit_load_extend.sv
// load_extend: pulls a byte/half/word/dword field out of a 64-bit memory word and
// sign- or zero-extends it. Purely combinational so a forwarding path can reuse it.
module load_extend
   import riscv_pkg::*;
(
   input  logic [REGISTER_WIDTH-1:0] data,
   input  logic [2:0]                offset,
   input  load_size_t                size,
   input  logic                      is_unsigned,
   output logic [REGISTER_WIDTH-1:0] value
);

   logic [REGISTER_WIDTH-1:0] shifted_s;
   logic                      sign_s;

   // Offset is in bytes; bytes shifted in from above bit 63 read as zero.
   assign shifted_s = data >> {offset, 3'b000};

   // Select field width and replicate the field MSB unless the load is unsigned.
   always_comb begin
      sign_s = 1'b0;
      value  = shifted_s;
      case (size)
         LS_B: begin
            sign_s = shifted_s[7] & ~is_unsigned;
            value  = {{(REGISTER_WIDTH-8){sign_s}}, shifted_s[7:0]};
         end
         LS_H: begin
            sign_s = shifted_s[15] & ~is_unsigned;
            value  = {{(REGISTER_WIDTH-16){sign_s}}, shifted_s[15:0]};
         end
         LS_W: begin
            sign_s = shifted_s[31] & ~is_unsigned;
            value  = {{(REGISTER_WIDTH-32){sign_s}}, shifted_s[31:0]};
         end
         LS_D: begin
            sign_s = 1'b0;
            value  = shifted_s;
         end
         default: begin
            sign_s = 1'b0;
            value  = shifted_s;
         end
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage -- retires ALU results and loads, and runs the ecall flush.
// Define WRITEBACK_DEBUG_EN to trace every register write and flush entry/exit.
module writeback_unit
   import riscv_pkg::*;
#(
   parameter int REGISTER_WIDTH   = riscv_pkg::REGISTER_WIDTH,
   parameter int REGISTERNO_WIDTH = riscv_pkg::REGISTERNO_WIDTH,
   parameter int ADDRESS_WIDTH    = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [ADDRESS_WIDTH-1:0]    in_pcplus1,
   input  logic [REGISTERNO_WIDTH-1:0] in_rd_regno,
   input  logic [REGISTER_WIDTH-1:0]   in_alu_result,
   input  logic                        in_is_load,
   input  logic [1:0]                  in_load_size,
   input  logic                        in_load_unsigned,
   input  logic [2:0]                  in_load_offset,
   input  logic                        in_is_ecall,
   input  logic                        in_mem_resp_valid,
   input  logic [REGISTER_WIDTH-1:0]   in_mem_resp_data,
   input  logic                        in_syscall_done,
   output logic                        out_ready,
   output logic [REGISTER_WIDTH-1:0]   out_wb_rd_value,
   output logic [REGISTERNO_WIDTH-1:0] out_wb_rd_regno,
   output logic                        out_wb_enable,
   output logic                        out_syscall_flush
);

   wb_state_t                   state_q, state_d;
   logic [REGISTER_WIDTH-1:0]   wb_value_q, wb_value_d;
   logic [REGISTERNO_WIDTH-1:0] wb_regno_q, wb_regno_d;
   logic                        wb_enable_q, wb_enable_d;
   logic                        flush_q, flush_d;
   logic [REGISTERNO_WIDTH-1:0] ld_regno_q, ld_regno_d;
   load_size_t                  ld_size_q, ld_size_d;
   logic                        ld_unsigned_q, ld_unsigned_d;
   logic [2:0]                  ld_offset_q, ld_offset_d;
   logic [ADDRESS_WIDTH-1:0]    pc_q, pc_d;

   logic                        accept_s;
   load_size_t                  ext_size_s;
   logic                        ext_unsigned_s;
   logic [2:0]                  ext_offset_s;
   logic [REGISTER_WIDTH-1:0]   ext_value_s;

   assign out_ready = (state_q == IDLE);
   assign accept_s  = in_valid & out_ready;

   // In IDLE the extender sees the incoming load so a same-cycle response retires at once.
   always_comb begin
      ext_size_s     = ld_size_q;
      ext_unsigned_s = ld_unsigned_q;
      ext_offset_s   = ld_offset_q;
      if (state_q == IDLE) begin
         ext_size_s     = load_size_t'(in_load_size);
         ext_unsigned_s = in_load_unsigned;
         ext_offset_s   = in_load_offset;
      end else begin
         ext_size_s     = ld_size_q;
         ext_unsigned_s = ld_unsigned_q;
         ext_offset_s   = ld_offset_q;
      end
   end

   load_extend u_load_extend (
      .data        (in_mem_resp_data),
      .offset      (ext_offset_s),
      .size        (ext_size_s),
      .is_unsigned (ext_unsigned_s),
      .value       (ext_value_s)
   );

   // Next-state and next-output logic for the writeback FSM.
   always_comb begin
      state_d       = state_q;
      wb_value_d    = wb_value_q;
      wb_regno_d    = wb_regno_q;
      wb_enable_d   = 1'b0;
      flush_d       = flush_q;
      ld_regno_d    = ld_regno_q;
      ld_size_d     = ld_size_q;
      ld_unsigned_d = ld_unsigned_q;
      ld_offset_d   = ld_offset_q;
      pc_d          = pc_q;
      case (state_q)
         IDLE: begin
            flush_d = 1'b0;
            if (accept_s) begin
               pc_d = in_pcplus1;
               if (in_is_ecall) begin
                  flush_d = 1'b1;
                  state_d = SYSCALL;
               end else if (in_is_load) begin
                  ld_regno_d    = in_rd_regno;
                  ld_size_d     = load_size_t'(in_load_size);
                  ld_unsigned_d = in_load_unsigned;
                  ld_offset_d   = in_load_offset;
                  if (in_mem_resp_valid) begin
                     wb_value_d  = ext_value_s;
                     wb_regno_d  = in_rd_regno;
                     wb_enable_d = (in_rd_regno != {REGISTERNO_WIDTH{1'b0}});
                     state_d     = IDLE;
                  end else begin
                     state_d = WAIT_LOAD;
                  end
               end else begin
                  wb_value_d  = in_alu_result;
                  wb_regno_d  = in_rd_regno;
                  wb_enable_d = (in_rd_regno != {REGISTERNO_WIDTH{1'b0}});
                  state_d     = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_LOAD: begin
            flush_d = 1'b0;
            if (in_mem_resp_valid) begin
               wb_value_d  = ext_value_s;
               wb_regno_d  = ld_regno_q;
               wb_enable_d = (ld_regno_q != {REGISTERNO_WIDTH{1'b0}});
               state_d     = IDLE;
            end else begin
               state_d = WAIT_LOAD;
            end
         end
         SYSCALL: begin
            if (in_syscall_done) begin
               flush_d = 1'b0;
               state_d = IDLE;
            end else begin
               flush_d = 1'b1;
               state_d = SYSCALL;
            end
         end
         default: begin
            flush_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any pending load or syscall.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wb_value_q    <= {REGISTER_WIDTH{1'b0}};
         wb_regno_q    <= {REGISTERNO_WIDTH{1'b0}};
         wb_enable_q   <= 1'b0;
         flush_q       <= 1'b0;
         ld_regno_q    <= {REGISTERNO_WIDTH{1'b0}};
         ld_size_q     <= LS_B;
         ld_unsigned_q <= 1'b0;
         ld_offset_q   <= 3'd0;
         pc_q          <= {ADDRESS_WIDTH{1'b0}};
      end else begin
         state_q       <= state_d;
         wb_value_q    <= wb_value_d;
         wb_regno_q    <= wb_regno_d;
         wb_enable_q   <= wb_enable_d;
         flush_q       <= flush_d;
         ld_regno_q    <= ld_regno_d;
         ld_size_q     <= ld_size_d;
         ld_unsigned_q <= ld_unsigned_d;
         ld_offset_q   <= ld_offset_d;
         pc_q          <= pc_d;
      end
   end

   assign out_wb_rd_value   = wb_value_q;
   assign out_wb_rd_regno   = wb_regno_q;
   assign out_wb_enable     = wb_enable_q;
   assign out_syscall_flush = flush_q;

`ifdef WRITEBACK_DEBUG_EN
   // Trace register writes and flush transitions.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wb_enable_q) begin
            $display("[wb] pc=%h x%0d <= %h", pc_q, wb_regno_q, wb_value_q);
         end else begin
         end
         if ((state_q == IDLE) && (state_d == SYSCALL)) begin
            $display("[wb] syscall flush enter pc=%h", in_pcplus1);
         end else if ((state_q == SYSCALL) && (state_d == IDLE)) begin
            $display("[wb] syscall flush exit");
         end else begin
         end
      end else begin
      end
   end
`else
   logic unused_pc_s;
   assign unused_pc_s = ^pc_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios then randomized
// instruction mixes checked against a behavioural load/retire model.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [63:0] in_pcplus1;
   logic [4:0]  in_rd_regno;
   logic [63:0] in_alu_result;
   logic        in_is_load;
   logic [1:0]  in_load_size;
   logic        in_load_unsigned;
   logic [2:0]  in_load_offset;
   logic        in_is_ecall;
   logic        in_mem_resp_valid;
   logic [63:0] in_mem_resp_data;
   logic        in_syscall_done;
   logic        out_ready;
   logic [63:0] out_wb_rd_value;
   logic [4:0]  out_wb_rd_regno;
   logic        out_wb_enable;
   logic        out_syscall_flush;

   int n_cmp  = 0;
   int n_fail = 0;

   // Last value/regno the register-file port should be holding.
   logic [63:0] exp_val;
   logic [4:0]  exp_reg;

   writeback_unit dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_pcplus1        (in_pcplus1),
      .in_rd_regno       (in_rd_regno),
      .in_alu_result     (in_alu_result),
      .in_is_load        (in_is_load),
      .in_load_size      (in_load_size),
      .in_load_unsigned  (in_load_unsigned),
      .in_load_offset    (in_load_offset),
      .in_is_ecall       (in_is_ecall),
      .in_mem_resp_valid (in_mem_resp_valid),
      .in_mem_resp_data  (in_mem_resp_data),
      .in_syscall_done   (in_syscall_done),
      .out_ready         (out_ready),
      .out_wb_rd_value   (out_wb_rd_value),
      .out_wb_rd_regno   (out_wb_rd_regno),
      .out_wb_enable     (out_wb_enable),
      .out_syscall_flush (out_syscall_flush)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: load result from byte offset, field width and signedness, by arithmetic.
   function automatic logic [63:0] model_load(input logic [63:0] data, input int off,
                                              input int size, input bit uns);
      int unsigned  nbits;
      logic [127:0] wide;
      logic [127:0] field;
      nbits = 8 * (2 ** size);
      wide  = {64'd0, data} / (128'd1 << (8 * off));
      field = wide % (128'd1 << nbits);
      if (!uns && (size != 3) && (field >= (128'd1 << (nbits - 1))))
         field = field + ((128'd1 << 64) - (128'd1 << nbits));
      return field[63:0];
   endfunction

   task automatic clear_in();
      in_valid          = 1'b0;
      in_is_load        = 1'b0;
      in_is_ecall       = 1'b0;
      in_mem_resp_valid = 1'b0;
      in_syscall_done   = 1'b0;
   endtask

   task automatic check_port(input string tag, input bit en);
      check({tag, "_en"}, {63'd0, out_wb_enable}, {63'd0, en});
      check({tag, "_reg"}, {59'd0, out_wb_rd_regno}, {59'd0, exp_reg});
      check({tag, "_val"}, out_wb_rd_value, exp_val);
   endtask

   task automatic idle_cycle(input string tag);
      clear_in();
      check({tag, "_rdy"}, {63'd0, out_ready}, 64'd1);
      tick();
      check({tag, "_idle_en"}, {63'd0, out_wb_enable}, 64'd0);
      check({tag, "_idle_fl"}, {63'd0, out_syscall_flush}, 64'd0);
   endtask

   task automatic do_alu(input string tag, input logic [4:0] rd, input logic [63:0] val);
      clear_in();
      in_valid         = 1'b1;
      in_rd_regno      = rd;
      in_alu_result    = val;
      in_pcplus1       = {$urandom, $urandom};
      in_load_size     = 2'($urandom);
      in_load_offset   = 3'($urandom);
      in_syscall_done  = 1'($urandom);
      check({tag, "_rdy"}, {63'd0, out_ready}, 64'd1);
      tick();
      clear_in();
      exp_val = val;
      exp_reg = rd;
      check_port(tag, rd != 5'd0);
   endtask

   task automatic do_load(input string tag, input logic [4:0] rd, input int size, input int off,
                          input bit uns, input logic [63:0] data, input int delay);
      clear_in();
      in_valid         = 1'b1;
      in_is_load       = 1'b1;
      in_rd_regno      = rd;
      in_load_size     = 2'(size);
      in_load_offset   = 3'(off);
      in_load_unsigned = uns;
      in_alu_result    = {$urandom, $urandom};
      in_mem_resp_data = (delay == 0) ? data : {$urandom, $urandom};
      in_mem_resp_valid = (delay == 0);
      check({tag, "_rdy"}, {63'd0, out_ready}, 64'd1);
      tick();
      for (int k = 1; k <= delay; k++) begin
         clear_in();
         in_valid         = 1'b1;
         in_rd_regno      = 5'($urandom);
         in_load_size     = 2'($urandom);
         in_load_offset   = 3'($urandom);
         in_load_unsigned = 1'($urandom);
         in_syscall_done  = 1'($urandom);
         check({tag, "_wait_en"}, {63'd0, out_wb_enable}, 64'd0);
         check({tag, "_wait_rdy"}, {63'd0, out_ready}, 64'd0);
         in_mem_resp_valid = (k == delay);
         in_mem_resp_data  = (k == delay) ? data : {$urandom, $urandom};
         tick();
      end
      clear_in();
      exp_val = model_load(data, off, size, uns);
      exp_reg = rd;
      check_port(tag, rd != 5'd0);
   endtask

   task automatic do_ecall(input string tag, input bit also_load, input int done_delay);
      clear_in();
      in_valid          = 1'b1;
      in_is_ecall       = 1'b1;
      in_is_load        = also_load;
      in_rd_regno       = 5'($urandom_range(1, 31));
      in_mem_resp_valid = also_load;
      check({tag, "_rdy"}, {63'd0, out_ready}, 64'd1);
      tick();
      clear_in();
      check({tag, "_fl_on"}, {63'd0, out_syscall_flush}, 64'd1);
      check_port({tag, "_nowr"}, 1'b0);
      for (int k = 1; k <= done_delay; k++) begin
         in_valid        = 1'b1;
         in_rd_regno     = 5'($urandom_range(1, 31));
         in_alu_result   = {$urandom, $urandom};
         in_syscall_done = (k == done_delay);
         check({tag, "_sys_rdy"}, {63'd0, out_ready}, 64'd0);
         check({tag, "_sys_fl"}, {63'd0, out_syscall_flush}, 64'd1);
         tick();
         clear_in();
         check({tag, "_sys_en"}, {63'd0, out_wb_enable}, 64'd0);
      end
      check({tag, "_fl_off"}, {63'd0, out_syscall_flush}, 64'd0);
      check({tag, "_rdy_back"}, {63'd0, out_ready}, 64'd1);
      check_port({tag, "_held"}, 1'b0);
   endtask

   initial begin
      clear_in();
      in_pcplus1       = 64'd0;
      in_rd_regno      = 5'd0;
      in_alu_result    = 64'd0;
      in_load_size     = 2'd0;
      in_load_unsigned = 1'b0;
      in_load_offset   = 3'd0;
      in_mem_resp_data = 64'd0;
      exp_val = 64'd0;
      exp_reg = 5'd0;

      reset = 1'b1;
      tick();
      tick();
      check("rst_rdy", {63'd0, out_ready}, 64'd1);
      check("rst_fl", {63'd0, out_syscall_flush}, 64'd0);
      check_port("rst", 1'b0);
      reset = 1'b0;

      do_alu("alu_x5", 5'd5, 64'h1234);
      idle_cycle("alu_one_pulse");
      do_load("lb_signed", 5'd10, 0, 3, 1'b0, 64'h00000000_80FF0000, 2);
      do_load("lhu_off6", 5'd11, 1, 6, 1'b1, 64'hBEEF0000_00000000, 1);
      do_load("lw_now", 5'd12, 2, 4, 1'b0, 64'h87654321_00000000, 0);
      do_load("ld_unsig", 5'd13, 3, 0, 1'b1, 64'hF000_0000_0000_0001, 3);
      do_load("lh_misal", 5'd14, 1, 7, 1'b0, 64'hFF00_0000_0000_0000, 1);
      do_alu("alu_x0", 5'd0, 64'hDEAD);
      idle_cycle("x0_after");
      do_ecall("ecall", 1'b0, 5);
      do_ecall("ecall_ld", 1'b1, 1);

      // Reset while a load is outstanding: the late response must not write.
      clear_in();
      in_valid       = 1'b1;
      in_is_load     = 1'b1;
      in_rd_regno    = 5'd9;
      in_load_size   = 2'd3;
      in_load_offset = 3'd0;
      tick();
      clear_in();
      check("wl_rdy", {63'd0, out_ready}, 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_val = 64'd0;
      exp_reg = 5'd0;
      check("wl_rst_rdy", {63'd0, out_ready}, 64'd1);
      in_mem_resp_valid = 1'b1;
      in_mem_resp_data  = 64'h1111_2222_3333_4444;
      tick();
      clear_in();
      check_port("wl_late_resp", 1'b0);
      check("wl_late_rdy", {63'd0, out_ready}, 64'd1);

      for (int i = 0; i < 300; i++) begin
         int sel;
         sel = $urandom_range(0, 10);
         if (sel <= 4)
            do_alu("r_alu", 5'($urandom), {$urandom, $urandom});
         else if (sel <= 8)
            do_load("r_load", 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 7),
                    1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
         else if (sel == 9)
            do_ecall("r_ecall", 1'($urandom), $urandom_range(1, 4));
         else
            idle_cycle("r_idle");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage. Accepts one retiring instruction per handshake from the memory stage.
- For loads, waits for the data-memory response, then byte-aligns, sign/zero-extends and merges it.
- Drives the register-file write port (value, regno, enable) consumed by decode.
- Owns the syscall-flush sequence: on ecall it holds the pipeline flushed until the syscall handler reports done.

Parameters:
- REGISTER_WIDTH, 64, architectural register / result width.
- REGISTERNO_WIDTH, 5, register index width.
- ADDRESS_WIDTH, 64, PC width (debug/trace only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  memory stage presents a retiring instruction.
- in_pcplus1  in  ADDRESS_WIDTH  PC of the instruction (trace only).
- in_rd_regno  in  REGISTERNO_WIDTH  destination register.
- in_alu_result  in  REGISTER_WIDTH  result for non-load instructions.
- in_is_load  in  1  instruction is a load.
- in_load_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- in_load_unsigned  in  1  zero-extend (lbu/lhu/lwu).
- in_load_offset  in  3  byte offset within the 64-bit memory word.
- in_is_ecall  in  1  instruction is ecall.
- in_mem_resp_valid  in  1  load data valid this cycle.
- in_mem_resp_data  in  REGISTER_WIDTH  aligned 64-bit memory word.
- in_syscall_done  in  1  syscall handler finished; single-cycle pulse.
- out_ready  out  1  unit accepts an instruction this cycle.
- out_wb_rd_value  out  REGISTER_WIDTH  register-file write data.
- out_wb_rd_regno  out  REGISTERNO_WIDTH  register-file write index.
- out_wb_enable  out  1  register-file write strobe.
- out_syscall_flush  out  1  flush request to fetch/decode/execute.

Behaviour:
- Reset: state=IDLE; all outputs 0 except out_ready=1. Reset in any state abandons the pending load/syscall with no write; a late in_mem_resp_valid is ignored.
- Handshake: an instruction is accepted when in_valid && out_ready. out_ready=1 only in IDLE and is combinational from state.
- IDLE, accepting a non-load, non-ecall instruction:
  - Next cycle: out_wb_enable=1, out_wb_rd_regno=in_rd_regno, out_wb_rd_value=in_alu_result.
  - Latency is 1 cycle; state stays IDLE, so back-to-back throughput is 1 per cycle.
- IDLE, accepting a load:
  - Latch regno, size, unsigned flag and offset; go to WAIT_LOAD.
  - If in_mem_resp_valid is already high in the acceptance cycle, the response is consumed that cycle, the write appears next cycle, and state stays IDLE.
- WAIT_LOAD, on in_mem_resp_valid:
  - Extract field = data >> (8*offset), masked to 8/16/32/64 bits.
  - Extend to 64 bits: sign-extend from the field MSB unless unsigned; size 3 ignores the unsigned flag.
  - Next cycle: write pulse; state returns to IDLE.
  - Misaligned offset (field crosses bit 63) is outside this unit's contract; bits above 63 read as 0.
- IDLE, accepting an ecall:
  - No register write. Next cycle out_syscall_flush=1; state=SYSCALL.
- SYSCALL: out_syscall_flush held 1 and out_ready=0 until in_syscall_done. On the cycle after done, flush=0 and state=IDLE.
- in_syscall_done outside SYSCALL is ignored.
- x0: rd_regno==0 forces out_wb_enable=0 (value/regno still driven).
- out_wb_enable is a single-cycle pulse per retired instruction; the value and regno registers hold their last written values when enable is 0.
- Simultaneous: in_is_load && in_is_ecall is illegal; ecall takes priority, with no load wait and no write.

Optional Feature:
- WRITEBACK_DEBUG_EN: when defined, each write pulse emits $display of pc, regno and value, and each flush entry/exit emits a line.
- When undefined: no $display calls; RTL is otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - wb_state_t enum {IDLE, WAIT_LOAD, SYSCALL};
  - load_size_t enum {LS_B, LS_H, LS_W, LS_D};
  - width constants REGISTER_WIDTH and REGISTERNO_WIDTH.
- One sub-module, load_extend: combinational extract plus sign/zero-extend (data, offset, size, unsigned -> 64-bit value). It is reusable by a future store-to-load forwarding path.

Test Plan:
- ALU write: in_valid, rd=5, alu=0x1234 -> next cycle wb_enable=1, regno=5, value=0x1234; one pulse only.
- Signed byte load: rd=10, size=0, offset=3, unsigned=0; resp 2 cycles later with data=0x00000000_80FF0000_ -> byte 0x80 -> value=0xFFFFFFFF_FFFFFF80; out_ready=0 while waiting.
- Unsigned half load: size=1, offset=6, unsigned=1, data=0xBEEF0000_00000000 -> value=0x00000000_0000BEEF.
- x0 suppression: rd=0, alu=0xDEAD -> wb_enable stays 0.
- Ecall: accept ecall -> flush=1 from next cycle, out_ready=0; in_syscall_done pulse after 5 cycles -> flush=0 next cycle, out_ready=1, no write occurred.
- Reset in WAIT_LOAD: reset asserted, then resp_valid arrives -> no write; state IDLE, out_ready=1.
